// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, PC width, reset vector.
package pc_sequencer_pkg;
   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      OUT_WAIT = 2'd1,
      HALTED   = 2'd2
   } seq_state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/IO-facing bundle of the PC sequencer; master drives decode, slave is the sequencer.
interface pc_sequencer_if;
   import pc_sequencer_pkg::*;
   logic            halt;
   logic            output_flag;
   logic            jump;
   logic            Jal;
   logic            JR;
   logic            Branch;
   logic            branch_cond;
   logic [15:0]     imm;
   logic [25:0]     jtarget;
   logic [PC_W-1:0] jr_addr;
   logic            out_ack;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] link_addr;
   logic            instr_valid;
   logic            out_req;
   logic            halted;
   logic [PC_W-1:0] instr_count;

   modport master (
      output halt, output_flag, jump, Jal, JR, Branch, branch_cond,
             imm, jtarget, jr_addr, out_ack,
      input  pc, link_addr, instr_valid, out_req, halted, instr_count
   );

   modport slave (
      input  halt, output_flag, jump, Jal, JR, Branch, branch_cond,
             imm, jtarget, jr_addr, out_ack,
      output pc, link_addr, instr_valid, out_req, halted, instr_count
   );
endinterface

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-address select for a flowing instruction (halt/output holds live in the FSM).
module next_pc_mux
   import pc_sequencer_pkg::*;
(
   input  logic [PC_W-1:0] i_pc,
   input  logic            i_jump,
   input  logic            i_jr,
   input  logic            i_branch,
   input  logic            i_branch_cond,
   input  logic [15:0]     i_imm,
   input  logic [25:0]     i_jtarget,
   input  logic [PC_W-1:0] i_jr_addr,
   output logic [PC_W-1:0] o_pc_plus1,
   output logic [PC_W-1:0] o_next_pc
);
   logic [PC_W-1:0] w_br_target;
   logic [PC_W-1:0] w_j_target;

   assign o_pc_plus1  = i_pc + 32'd1;
   assign w_br_target = o_pc_plus1 + {{16{i_imm[15]}}, i_imm};
   assign w_j_target  = {o_pc_plus1[31:26], i_jtarget};

   // JR beats jump beats a taken branch.
   always_comb begin
      o_next_pc = o_pc_plus1;
      if (i_jr)
         o_next_pc = i_jr_addr;
      else if (i_jump)
         o_next_pc = w_j_target;
      else if (i_branch && i_branch_cond)
         o_next_pc = w_br_target;
   end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: RUN / OUT_WAIT / HALTED FSM, pc register and retire counter.
module pc_sequencer
   import pc_sequencer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   pc_sequencer_if.slave bus
);
   seq_state_e      r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_instr_count;
   logic            r_out_req;
   logic            r_halted;
   logic [PC_W-1:0] w_pc_plus1;
   logic [PC_W-1:0] w_next_pc;

   next_pc_mux u_next_pc_mux (
      .i_pc          (r_pc),
      .i_jump        (bus.jump),
      .i_jr          (bus.JR),
      .i_branch      (bus.Branch),
      .i_branch_cond (bus.branch_cond),
      .i_imm         (bus.imm),
      .i_jtarget     (bus.jtarget),
      .i_jr_addr     (bus.jr_addr),
      .o_pc_plus1    (w_pc_plus1),
      .o_next_pc     (w_next_pc)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= RUN;
         r_pc          <= RESET_PC;
         r_instr_count <= '0;
         r_out_req     <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (bus.halt) begin
                  r_state  <= HALTED;
                  r_halted <= 1'b1;
               end else if (bus.output_flag) begin
                  r_state   <= OUT_WAIT;
                  r_out_req <= 1'b1;
               end else begin
                  r_pc          <= w_next_pc;
                  r_instr_count <= r_instr_count + 32'd1;
               end
            end
            OUT_WAIT: begin
               // The OUTPUT instruction retires only once the device takes the value.
               if (bus.out_ack) begin
                  r_state       <= RUN;
                  r_out_req     <= 1'b0;
                  r_pc          <= w_pc_plus1;
                  r_instr_count <= r_instr_count + 32'd1;
               end
            end
            HALTED: ;
            default: begin
               r_state   <= RUN;
               r_out_req <= 1'b0;
               r_halted  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc          = r_pc;
   assign bus.link_addr   = w_pc_plus1;
   assign bus.out_req     = r_out_req;
   assign bus.halted      = r_halted;
   assign bus.instr_count = r_instr_count;
   assign bus.instr_valid = !reset && (r_state == RUN) && !bus.halt;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random decode streams vs. a behavioural model.
module tb_pc_sequencer;
   logic clock = 1'b0;
   logic reset;
   pc_sequencer_if bus ();

   pc_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   typedef struct packed {
      logic        rst, halt, outf, jump, jal, jr, br, bc, ack, fc;
      logic [15:0] imm;
      logic [25:0] jt;
      logic [31:0] ja;
   } stim_t;

   typedef struct {
      bit          chk_reg;
      logic [31:0] pc, cnt, link;
      logic        oreq, hlt, iv;
   } exp_t;

   typedef enum {M_RUN, M_WAIT, M_STOP} mstate_e;

   exp_t        q[$];
   int          tests = 0;
   int          failed = 0;
   mstate_e     m_st = M_RUN;
   logic [31:0] m_pc = 0, m_cnt = 0;
   bit          m_known = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic stim_t nop();
      stim_t s = '0;
      return s;
   endfunction

   // One instruction slot: apply inputs at negedge, record what must be seen before the next edge.
   task automatic drive(input stim_t s);
      exp_t        e;
      logic [31:0] nxt;
      @(negedge clock);
      if (s.fc) begin
         dut.r_instr_count = 32'hFFFF_FFFF;
         m_cnt = 32'hFFFF_FFFF;
      end
      reset = s.rst;
      bus.halt = s.halt; bus.output_flag = s.outf; bus.jump = s.jump; bus.Jal = s.jal;
      bus.JR = s.jr; bus.Branch = s.br; bus.branch_cond = s.bc; bus.out_ack = s.ack;
      bus.imm = s.imm; bus.jtarget = s.jt; bus.jr_addr = s.ja;
      e.chk_reg = m_known;
      e.pc   = m_pc;
      e.cnt  = m_cnt;
      e.link = m_pc + 1;
      e.oreq = (m_st == M_WAIT);
      e.hlt  = (m_st == M_STOP);
      e.iv   = !s.rst && m_st == M_RUN && !s.halt;
      q.push_back(e);
      if (s.rst) begin
         m_st = M_RUN; m_pc = 0; m_cnt = 0; m_known = 1;
      end else if (m_st == M_RUN) begin
         if (s.halt) m_st = M_STOP;
         else if (s.outf) m_st = M_WAIT;
         else begin
            if (s.jr) nxt = s.ja;
            else if (s.jump) nxt = ((m_pc + 1) & 32'hFC00_0000) | {6'd0, s.jt};
            else if (s.br && s.bc) nxt = m_pc + 1 + 32'(signed'(s.imm));
            else nxt = m_pc + 1;
            m_pc = nxt;
            m_cnt = m_cnt + 1;
         end
      end else if (m_st == M_WAIT && s.ack) begin
         m_st = M_RUN; m_pc = m_pc + 1; m_cnt = m_cnt + 1;
      end
   endtask

   task automatic go_to(input logic [31:0] a);
      stim_t s = nop();
      s.jr = 1; s.ja = a;
      drive(s);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         #3;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, e.iv});
            if (e.chk_reg) begin
               chk("pc", bus.pc, e.pc);
               chk("instr_count", bus.instr_count, e.cnt);
               chk("link_addr", bus.link_addr, e.link);
               chk("out_req", {31'd0, bus.out_req}, {31'd0, e.oreq});
               chk("halted", {31'd0, bus.halted}, {31'd0, e.hlt});
            end
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      reset = 1;
      bus.halt = 0; bus.output_flag = 0; bus.jump = 0; bus.Jal = 0; bus.JR = 0;
      bus.Branch = 0; bus.branch_cond = 0; bus.out_ack = 0;
      bus.imm = 0; bus.jtarget = 0; bus.jr_addr = 0;

      s = nop(); s.rst = 1; drive(s);
      repeat (5) drive(nop());

      go_to(10);
      s = nop(); s.br = 1; s.bc = 1; s.imm = 16'hFFFC; drive(s);
      go_to(10);
      s = nop(); s.br = 1; s.bc = 0; s.imm = 16'hFFFC; drive(s);
      s = nop(); s.jump = 1; s.br = 1; s.bc = 1; s.imm = 16'h0100; s.jt = 26'h55; drive(s);
      s = nop(); s.jr = 1; s.jump = 1; s.ja = 32'h1234_5678; s.jt = 26'h3; drive(s);

      go_to(32'h0400_0005);
      s = nop(); s.jump = 1; s.jal = 1; s.jt = 26'h20; drive(s);
      s = nop(); s.jr = 1; s.ja = 32'h0400_0006; drive(s);
      go_to(32'hFFFF_FFFF);
      s = nop(); s.br = 1; s.bc = 1; s.imm = 16'h0003; drive(s);

      go_to(5);
      s = nop(); s.outf = 1; drive(s);
      s = nop(); s.jump = 1; s.jt = 26'h77; repeat (3) drive(s);
      s = nop(); s.ack = 1; drive(s);
      drive(nop());

      go_to(9);
      s = nop(); s.ack = 1; drive(s);
      s = nop(); s.halt = 1; drive(s);
      for (int i = 0; i < 6; i++) begin
         s = nop(); s.jump = i[0]; s.ack = i[1]; s.outf = i[2]; s.jt = 26'h1F; drive(s);
      end
      s = nop(); s.rst = 1; drive(s);
      drive(nop());

      s = nop(); s.fc = 1; drive(s);
      drive(nop());

      s = nop(); s.outf = 1; drive(s);
      s = nop(); s.rst = 1; s.ack = 1; drive(s);
      drive(nop());

      for (int i = 0; i < 500; i++) begin
         s = nop();
         s.rst  = ($urandom_range(0, 59) == 0) || (m_st == M_STOP && $urandom_range(0, 5) == 0);
         s.halt = ($urandom_range(0, 39) == 0);
         s.outf = ($urandom_range(0, 7) == 0);
         s.jump = ($urandom_range(0, 3) == 0);
         s.jal  = $urandom_range(0, 1);
         s.jr   = ($urandom_range(0, 5) == 0);
         s.br   = $urandom_range(0, 1);
         s.bc   = $urandom_range(0, 1);
         s.ack  = ($urandom_range(0, 2) == 0);
         s.fc   = ($urandom_range(0, 99) == 0);
         s.imm  = 16'($urandom);
         s.jt   = 26'($urandom);
         s.ja   = $urandom;
         drive(s);
      end

      @(negedge clock);
      #5;
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
